// File: rtl/ifft_seq_pkg.sv
// Shared types and constants for the IFFT frame sequencer.
// Optional IFFT_SEQ_CONJ_SAT_EN makes conjugate negation of the most negative value saturate.
package ifft_seq_pkg;

    localparam int DATA_W = 28;
    localparam int N_FFT  = 128;
    localparam int N_SC   = 63;
    localparam int IDX_W  = 7;
    localparam int PTR_W  = 6;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    function automatic logic signed [DATA_W-1:0] conj_neg(input logic signed [DATA_W-1:0] x);
`ifdef IFFT_SEQ_CONJ_SAT_EN
        if (x == {1'b1, {(DATA_W-1){1'b0}}}) return {1'b0, {(DATA_W-1){1'b1}}};
`endif
        return -x;
    endfunction

endpackage

// File: rtl/ifft_sym_buffer.sv
// 63-entry complex symbol store: one synchronous write port, one asynchronous read port.
module ifft_sym_buffer
    import ifft_seq_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  cplx_t            wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output cplx_t            rd_data
);

    cplx_t mem [N_SC];

    // NOTE: storage is deliberately not reset; every entry is rewritten by a full fill before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ifft_frame_sequencer.sv
// Collects 63 QAM symbols, then streams a Hermitian-symmetric 128-bin frame into the IFFT.
// Build option IFFT_SEQ_CONJ_SAT_EN selects saturating conjugate negation.
module ifft_frame_sequencer
    import ifft_seq_pkg::*;
(
    input  logic              SYS_CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] S_SYM_RE_IN,
    input  logic [DATA_W-1:0] S_SYM_IM_IN,
    input  logic              S_SYM_VALID,
    output logic              S_SYM_READY,
    output logic [DATA_W-1:0] M_DATA_RE_OUT,
    output logic [DATA_W-1:0] M_DATA_IM_OUT,
    output logic              M_DATA_VALID,
    output logic              M_DATA_LAST,
    input  logic              M_DATA_READY,
    input  logic              EVENT_TLAST_UNEXPECTED,
    input  logic              EVENT_TLAST_MISSING,
    input  logic              EVENT_FFT_OVERFLOW,
    output logic [15:0]       FRAME_CNT,
    output logic [7:0]        ERR_CNT,
    output logic              ERR_FLAG
);

    localparam logic [IDX_W-1:0] NYQ      = IDX_W'(N_FFT / 2);
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(N_FFT - 1);

    state_t           state, state_n;
    logic [PTR_W-1:0] ptr, ptr_n, rd_addr;
    logic [IDX_W-1:0] bin, bin_n, bin_nxt;
    logic             sym_ready, sym_ready_n;
    logic             valid, valid_n, last, last_n;
    cplx_t            sample, sample_n, rd_data, wr_data;
    logic [15:0]      frame_cnt, frame_cnt_n;
    logic [7:0]       err_cnt;
    logic             err_flag;
    logic             sym_hs, data_hs, err_any;

    assign sym_hs  = sym_ready & S_SYM_VALID;
    assign data_hs = valid & M_DATA_READY;
    assign err_any = EVENT_TLAST_UNEXPECTED | EVENT_TLAST_MISSING | EVENT_FFT_OVERFLOW;
    assign bin_nxt = bin + IDX_W'(1);
    assign wr_data = '{re: S_SYM_RE_IN, im: S_SYM_IM_IN};

    // Upper bins mirror the lower ones: bin k reads buffer[k-1] below Nyquist, buffer[127-k] above.
    always_comb begin
        rd_addr = '0;
        if (bin_nxt > NYQ) rd_addr = PTR_W'(LAST_BIN - bin_nxt);
        else if (bin_nxt != '0 && bin_nxt != NYQ) rd_addr = PTR_W'(bin_nxt - IDX_W'(1));
    end

    ifft_sym_buffer u_buf (
        .clk     (SYS_CLK),
        .wr_en   (sym_hs),
        .wr_addr (ptr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_n     = state;
        ptr_n       = ptr;
        bin_n       = bin;
        sym_ready_n = sym_ready;
        valid_n     = valid;
        last_n      = last;
        sample_n    = sample;
        frame_cnt_n = frame_cnt;
        case (state)
            FILL: begin
                sym_ready_n = 1'b1;
                if (sym_hs) begin
                    if (ptr == PTR_W'(N_SC - 1)) begin
                        ptr_n       = '0;
                        sym_ready_n = 1'b0;
                        state_n     = STREAM;
                        valid_n     = 1'b1;
                        last_n      = 1'b0;
                        bin_n       = '0;
                        sample_n    = '0;
                    end else begin
                        ptr_n = ptr + PTR_W'(1);
                    end
                end
            end
            STREAM: begin
                if (data_hs) begin
                    if (bin == LAST_BIN) begin
                        valid_n     = 1'b0;
                        last_n      = 1'b0;
                        sample_n    = '0;
                        frame_cnt_n = frame_cnt + 16'd1;
                        state_n     = FILL;
                        sym_ready_n = 1'b1;
                    end else begin
                        bin_n  = bin_nxt;
                        last_n = (bin_nxt == LAST_BIN);
                        if (bin_nxt == NYQ)     sample_n = '0;
                        else if (bin_nxt < NYQ) sample_n = rd_data;
                        else                    sample_n = '{re: rd_data.re, im: conj_neg(rd_data.im)};
                    end
                end
            end
            default: state_n = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge SYS_CLK) begin
        if (!RST_N) begin
            state     <= FILL;
            ptr       <= '0;
            bin       <= '0;
            sym_ready <= 1'b0;
            valid     <= 1'b0;
            last      <= 1'b0;
            sample    <= '0;
            frame_cnt <= '0;
            err_cnt   <= '0;
            err_flag  <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            bin       <= bin_n;
            sym_ready <= sym_ready_n;
            valid     <= valid_n;
            last      <= last_n;
            sample    <= sample_n;
            frame_cnt <= frame_cnt_n;
            if (err_any) begin
                err_flag <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign S_SYM_READY   = sym_ready;
    assign M_DATA_RE_OUT = sample.re;
    assign M_DATA_IM_OUT = sample.im;
    assign M_DATA_VALID  = valid;
    assign M_DATA_LAST   = last;
    assign FRAME_CNT     = frame_cnt;
    assign ERR_CNT       = err_cnt;
    assign ERR_FLAG      = err_flag;

endmodule
